// File: rtl/sim_test_finish_ctrl.sv
// Simulation-only test completion controller: latches a pass/fail verdict from SW status
// writes, the legacy GPIO signature or a cycle watchdog, drains, then requests $finish.
module sim_test_finish_ctrl #(
   parameter logic [31:0] StatusAddr    = 32'h0041_0000,
   parameter int unsigned DrainCycles   = 7,
   parameter logic [31:0] TimeoutCycles = 32'd0,
   parameter logic [31:0] GpioSignature = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_valid_i,
   input  logic [31:0] wr_addr_i,
   input  logic [15:0] wr_data_i,
   input  logic [31:0] gpio_i,
   output logic [15:0] sw_status_o,
   output logic        test_done_o,
   output logic        test_passed_o,
   output logic        timeout_o,
   output logic        finish_req_o
);

   localparam logic [15:0] StatusPass = 16'h900D;
   localparam logic [15:0] StatusFail = 16'hBAAD;
   localparam logic [7:0]  DrainLimit = 8'(DrainCycles);
   localparam logic [31:0] WdExpire   = TimeoutCycles - 32'd1;
   localparam bit          WdEnable   = (TimeoutCycles != 32'd0);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   // Watchdog count holds at all-ones so a huge limit can never be skipped by wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_e      state;
   logic [7:0]  drain_cnt;
   logic [7:0]  drain_nxt;
   logic [31:0] wd_cnt;

   logic        status_wr;
   logic        fail_wr;
   logic        pass_wr;
   logic        gpio_hit;
   logic        wd_expired;
   logic        trig;
   logic        trig_pass;
   logic        trig_tmo;

   assign status_wr  = wr_valid_i && (wr_addr_i == StatusAddr);
   assign fail_wr    = status_wr && (wr_data_i == StatusFail);
   assign pass_wr    = status_wr && (wr_data_i == StatusPass);
   assign gpio_hit   = (gpio_i == GpioSignature);
   assign wd_expired = WdEnable && (wd_cnt == WdExpire);
   assign drain_nxt  = drain_cnt + 8'd1;

   // Verdict arbitration: fail write > pass write > GPIO signature > watchdog.
   always_comb begin
      trig      = 1'b0;
      trig_pass = 1'b0;
      trig_tmo  = 1'b0;
      if (fail_wr) begin
         trig = 1'b1;
      end else if (pass_wr || gpio_hit) begin
         trig      = 1'b1;
         trig_pass = 1'b1;
      end else if (wd_expired) begin
         trig     = 1'b1;
         trig_tmo = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= ST_RUN;
         drain_cnt     <= 8'd0;
         wd_cnt        <= 32'd0;
         sw_status_o   <= 16'd0;
         test_done_o   <= 1'b0;
         test_passed_o <= 1'b0;
         timeout_o     <= 1'b0;
         finish_req_o  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               wd_cnt <= sat_inc32(wd_cnt);
               if (status_wr) begin
                  sw_status_o <= wr_data_i;
               end
               if (trig) begin
                  state         <= ST_DRAIN;
                  drain_cnt     <= 8'd0;
                  test_done_o   <= 1'b1;
                  test_passed_o <= trig_pass;
                  timeout_o     <= trig_tmo;
               end
            end
            ST_DRAIN: begin
               drain_cnt <= drain_nxt;
               if (drain_nxt == DrainLimit) begin
                  state        <= ST_FINISH;
                  finish_req_o <= 1'b1;
               end
            end
            ST_FINISH: begin
               state <= ST_FINISH;
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule
